// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the Mini SRC datapath: IR/stop in, decoded strobes out.
// Outputs are combinational from sequencer state; there is no backpressure.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        stop;
  logic [4:0]  alu_op;
  logic        IncPC;
  logic [9:0]  bus_out;
  logic [11:0] reg_in;
  logic [2:0]  gr_sel;
  logic [1:0]  mem;
  logic        run;

  modport master (
    input  ir, stop,
    output alu_op, IncPC, bus_out, reg_in, gr_sel, mem, run
  );

  modport slave (
    output ir, stop,
    input  alu_op, IncPC, bus_out, reg_in, gr_sel, mem, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Mini SRC control unit: one T-step per clock, Moore decode of (state, opcode), 3-8 cycles per instruction.
// No backpressure: memory is fixed latency and the datapath consumes every strobe in its cycle.
module control_sequencer (
  input  logic               clock,
  input  logic               reset,
  control_sequencer_if.master ctl
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NONE, C_HALT
  } iclass_t;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_NOP = 5'b11010;
  localparam logic [4:0] ALU_BR  = 5'b10011;

  localparam logic [9:0] PCOUT   = 10'b1000000000;
  localparam logic [9:0] MDROUT  = 10'b0100000000;
  localparam logic [9:0] ZLOWOUT = 10'b0010000000;
  localparam logic [9:0] ZHIOUT  = 10'b0001000000;
  localparam logic [9:0] HIOUT   = 10'b0000100000;
  localparam logic [9:0] LOOUT   = 10'b0000010000;
  localparam logic [9:0] ROUT    = 10'b0000001000;
  localparam logic [9:0] BAOUT   = 10'b0000000100;
  localparam logic [9:0] COUT    = 10'b0000000010;
  localparam logic [9:0] INOUT   = 10'b0000000001;

  localparam logic [11:0] PCIN   = 12'b100000000000;
  localparam logic [11:0] MARIN  = 12'b010000000000;
  localparam logic [11:0] MDRIN  = 12'b001000000000;
  localparam logic [11:0] IRIN   = 12'b000100000000;
  localparam logic [11:0] YIN    = 12'b000010000000;
  localparam logic [11:0] ZIN    = 12'b000001000000;
  localparam logic [11:0] HIIN   = 12'b000000100000;
  localparam logic [11:0] LOIN   = 12'b000000010000;
  localparam logic [11:0] CONIN  = 12'b000000001000;
  localparam logic [11:0] OPIN   = 12'b000000000100;
  localparam logic [11:0] RIN    = 12'b000000000010;
  localparam logic [11:0] R15IN  = 12'b000000000001;

  localparam logic [2:0] GRA = 3'b100;
  localparam logic [2:0] GRB = 3'b010;
  localparam logic [2:0] GRC = 3'b001;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] WR  = 2'b01;

  state_t      state, nxt;
  iclass_t     cls;
  state_t      last;
  logic [4:0]  op;
  logic [4:0]  imm_op;
  logic [4:0]  alu_op;
  logic        inc_pc;
  logic [9:0]  bus_sel;
  logic [11:0] ld_sel;
  logic [2:0]  gr;
  logic [1:0]  mem_sel;

  assign op = ctl.ir[31:27];

  always_comb begin
    cls  = C_NONE;
    last = S_T2;
    case (op)
      5'b00000: begin cls = C_LD;     last = S_T7; end
      5'b00001: begin cls = C_LDI;    last = S_T5; end
      5'b00010: begin cls = C_ST;     last = S_T7; end
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011:
                begin cls = C_ALU;    last = S_T5; end
      5'b01100, 5'b01101, 5'b01110:
                begin cls = C_IMM;    last = S_T5; end
      5'b01111, 5'b10000:
                begin cls = C_MULDIV; last = S_T6; end
      5'b10001, 5'b10010:
                begin cls = C_UNARY;  last = S_T4; end
      5'b10011: begin cls = C_BR;     last = S_T6; end
      5'b10100: begin cls = C_JR;     last = S_T3; end
      5'b10101: begin cls = C_JAL;    last = S_T4; end
      5'b10110: begin cls = C_IN;     last = S_T3; end
      5'b10111: begin cls = C_OUT;    last = S_T3; end
      5'b11000: begin cls = C_MFHI;   last = S_T3; end
      5'b11001: begin cls = C_MFLO;   last = S_T3; end
      5'b11011: begin cls = C_HALT;   last = S_T2; end
      default:  begin cls = C_NONE;   last = S_T2; end
    endcase
  end

  // The ALU has no immediate codes, so addi/andi/ori borrow add/and/or.
  assign imm_op = (op == 5'b01101) ? ALU_AND :
                  (op == 5'b01110) ? ALU_OR  : ALU_ADD;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_RST;
    else        state <= nxt;
  end

  // T7 also terminates, so an IR change mid-instruction can never walk past the last step.
  always_comb begin
    nxt = state;
    case (state)
      S_RST:  nxt = S_T0;
      S_HALT: nxt = S_HALT;
      default: begin
        if (state == S_T2 && cls == C_HALT)      nxt = S_HALT;
        else if (state == last || state == S_T7) nxt = ctl.stop ? S_HALT : S_T0;
        else                                     nxt = state_t'(state + 4'd1);
      end
    endcase
  end

  always_comb begin
    alu_op  = 5'b00000;
    inc_pc  = 1'b0;
    bus_sel = 10'b0;
    ld_sel  = 12'b0;
    gr      = 3'b000;
    mem_sel = 2'b00;
    if (state != S_RST && state != S_HALT) alu_op = ALU_NOP;
    case (state)
      S_T0: begin bus_sel = PCOUT; ld_sel = MARIN | ZIN; inc_pc = 1'b1; alu_op = ALU_ADD; end
      S_T1: begin bus_sel = ZLOWOUT; ld_sel = PCIN | MDRIN; mem_sel = RD; end
      S_T2: begin bus_sel = MDROUT; ld_sel = IRIN; end
      S_T3: begin
        case (cls)
          C_ALU, C_IMM: begin bus_sel = ROUT; ld_sel = YIN; gr = GRB; end
          C_MULDIV:     begin bus_sel = ROUT; ld_sel = YIN; gr = GRA; end
          C_UNARY:      begin bus_sel = ROUT; ld_sel = ZIN; gr = GRB; alu_op = op; end
          C_LD, C_LDI, C_ST: begin bus_sel = BAOUT; ld_sel = YIN; gr = GRB; end
          C_BR:         begin bus_sel = ROUT; ld_sel = CONIN; gr = GRA; end
          C_JR:         begin bus_sel = ROUT; ld_sel = PCIN; gr = GRA; end
          C_JAL:        begin bus_sel = PCOUT; ld_sel = R15IN; end
          C_IN:         begin bus_sel = INOUT; ld_sel = RIN; gr = GRA; end
          C_OUT:        begin bus_sel = ROUT; ld_sel = OPIN; gr = GRA; end
          C_MFHI:       begin bus_sel = HIOUT; ld_sel = RIN; gr = GRA; end
          C_MFLO:       begin bus_sel = LOOUT; ld_sel = RIN; gr = GRA; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU:    begin bus_sel = ROUT; ld_sel = ZIN; gr = GRC; alu_op = op; end
          C_IMM:    begin bus_sel = COUT; ld_sel = ZIN; alu_op = imm_op; end
          C_MULDIV: begin bus_sel = ROUT; ld_sel = ZIN; gr = GRB; alu_op = op; end
          C_UNARY:  begin bus_sel = ZLOWOUT; ld_sel = RIN; gr = GRA; end
          C_LD, C_LDI, C_ST: begin bus_sel = COUT; ld_sel = ZIN; alu_op = ALU_ADD; end
          C_BR:     begin bus_sel = PCOUT; ld_sel = YIN; end
          C_JAL:    begin bus_sel = ROUT; ld_sel = PCIN; gr = GRA; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_IMM, C_LDI: begin bus_sel = ZLOWOUT; ld_sel = RIN; gr = GRA; end
          C_MULDIV: begin bus_sel = ZLOWOUT; ld_sel = LOIN; end
          C_LD, C_ST: begin bus_sel = ZLOWOUT; ld_sel = MARIN; end
          C_BR:     begin bus_sel = COUT; ld_sel = ZIN; alu_op = ALU_BR; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MULDIV: begin bus_sel = ZHIOUT; ld_sel = HIIN; end
          C_LD:     begin ld_sel = MDRIN; mem_sel = RD; end
          C_ST:     begin bus_sel = ROUT; ld_sel = MDRIN; gr = GRA; end
          C_BR:     begin bus_sel = ZLOWOUT; ld_sel = PCIN; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin bus_sel = MDROUT; ld_sel = RIN; gr = GRA; end
          C_ST: mem_sel = WR;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ctl.alu_op  = alu_op;
  assign ctl.IncPC   = inc_pc;
  assign ctl.bus_out = bus_sel;
  assign ctl.reg_in  = ld_sel;
  assign ctl.gr_sel  = gr;
  assign ctl.mem     = mem_sel;
  assign ctl.run     = (state != S_RST) && (state != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: driver queues hand-written per-cycle output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_control_sequencer;

  logic clock;
  logic reset;
  control_sequencer_if ctl ();

  control_sequencer dut (.clock(clock), .reset(reset), .ctl(ctl));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [9:0] PCO = 10'h200, MDRO = 10'h100, ZLO = 10'h080, ZHO = 10'h040,
                         HIO = 10'h020, LOO = 10'h010, RO = 10'h008, BAO = 10'h004,
                         CO = 10'h002, INO = 10'h001;
  localparam logic [11:0] PCI = 12'h800, MARI = 12'h400, MDRI = 12'h200, IRI = 12'h100,
                          YI = 12'h080, ZI = 12'h040, HII = 12'h020, LOI = 12'h010,
                          CONI = 12'h008, OPI = 12'h004, RI = 12'h002, R15I = 12'h001;
  localparam logic [2:0] GA = 3'b100, GB = 3'b010, GC = 3'b001;
  localparam logic [1:0] RD = 2'b10, WR = 2'b01;
  localparam logic [4:0] NA = 5'b11010;
  localparam logic [33:0] Z = 34'd0;

  logic [33:0] sb_exp [$];
  string       sb_tag [$];
  string       tag;
  int          n_cmp = 0;
  int          n_bad = 0;

  // {alu_op, IncPC, bus_out, reg_in, gr_sel, mem, run}
  function automatic logic [33:0] ev(input logic [4:0] a, input logic i, input logic [9:0] b,
                                     input logic [11:0] r, input logic [2:0] g, input logic [1:0] m);
    return {a, i, b, r, g, m, 1'b1};
  endfunction

  always @(negedge clock) begin
    if (sb_exp.size() > 0) begin
      logic [33:0] e, a;
      string       t;
      e = sb_exp.pop_front();
      t = sb_tag.pop_front();
      a = {ctl.alu_op, ctl.IncPC, ctl.bus_out, ctl.reg_in, ctl.gr_sel, ctl.mem, ctl.run};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s @%0t: got %b, expected %b", t, $time, a, e);
      end
    end
  end

  task automatic step(input logic [33:0] e, input string name);
    @(posedge clock);
    #1;
    sb_exp.push_back(e);
    sb_tag.push_back(name);
  endtask

  task automatic fetch(input logic [31:0] irv);
    step(ev(5'b00011, 1'b1, PCO, MARI | ZI, 3'b000, 2'b00), {tag, " T0"});
    ctl.ir = irv;
    step(ev(NA, 1'b0, ZLO, PCI | MDRI, 3'b000, RD), {tag, " T1"});
    step(ev(NA, 1'b0, MDRO, IRI, 3'b000, 2'b00), {tag, " T2"});
  endtask

  task automatic do_reset();
    step(Z, {tag, " rst"});
    reset = 1'b0;
    step(Z, {tag, " rst"});
    reset = 1'b1;
  endtask

  task automatic alu3(input logic [4:0] op);
    fetch({op, 27'h0});
    step(ev(NA, 1'b0, RO, YI, GB, 2'b00), {tag, " T3"});
    step(ev(op, 1'b0, RO, ZI, GC, 2'b00), {tag, " T4"});
    step(ev(NA, 1'b0, ZLO, RI, GA, 2'b00), {tag, " T5"});
  endtask

  task automatic imm(input logic [4:0] op, input logic [4:0] code);
    fetch({op, 27'h0});
    step(ev(NA, 1'b0, RO, YI, GB, 2'b00), {tag, " T3"});
    step(ev(code, 1'b0, CO, ZI, 3'b000, 2'b00), {tag, " T4"});
    step(ev(NA, 1'b0, ZLO, RI, GA, 2'b00), {tag, " T5"});
  endtask

  task automatic muldiv(input logic [4:0] op);
    fetch({op, 27'h0});
    step(ev(NA, 1'b0, RO, YI, GA, 2'b00), {tag, " T3"});
    step(ev(op, 1'b0, RO, ZI, GB, 2'b00), {tag, " T4"});
    step(ev(NA, 1'b0, ZLO, LOI, 3'b000, 2'b00), {tag, " T5"});
    step(ev(NA, 1'b0, ZHO, HII, 3'b000, 2'b00), {tag, " T6"});
  endtask

  task automatic addr_calc(input logic [4:0] op);
    fetch({op, 27'h0});
    step(ev(NA, 1'b0, BAO, YI, GB, 2'b00), {tag, " T3"});
    step(ev(5'b00011, 1'b0, CO, ZI, 3'b000, 2'b00), {tag, " T4"});
  endtask

  task automatic one_step(input logic [4:0] op, input logic [9:0] b, input logic [11:0] r);
    fetch({op, 27'h0});
    step(ev(NA, 1'b0, b, r, GA, 2'b00), {tag, " T3"});
  endtask

  initial begin
    reset  = 1'b1;
    ctl.ir = 32'h0;
    ctl.stop = 1'b0;
    #1 reset = 1'b0;

    tag = "reset";
    for (int i = 0; i < 3; i++) step(Z, tag);
    reset = 1'b1;

    tag = "add";  // ir 32'h19A20000
    fetch(32'h19A20000);
    step(ev(NA, 1'b0, RO, YI, GB, 2'b00), "add T3");
    step(ev(5'b00011, 1'b0, RO, ZI, GC, 2'b00), "add T4");
    step(ev(NA, 1'b0, ZLO, RI, GA, 2'b00), "add T5");
    tag = "sub"; alu3(5'b00100);
    tag = "rol"; alu3(5'b01000);

    tag = "andi"; imm(5'b01101, 5'b00101);
    tag = "addi"; imm(5'b01100, 5'b00011);
    tag = "ori";  imm(5'b01110, 5'b00110);

    tag = "mul"; muldiv(5'b01111);
    tag = "div"; muldiv(5'b10000);

    tag = "st"; addr_calc(5'b00010);
    step(ev(NA, 1'b0, ZLO, MARI, 3'b000, 2'b00), "st T5");
    step(ev(NA, 1'b0, RO, MDRI, GA, 2'b00), "st T6");
    step(ev(NA, 1'b0, 10'h0, 12'h0, 3'b000, WR), "st T7");

    tag = "ld"; addr_calc(5'b00000);
    step(ev(NA, 1'b0, ZLO, MARI, 3'b000, 2'b00), "ld T5");
    step(ev(NA, 1'b0, 10'h0, MDRI, 3'b000, RD), "ld T6");
    step(ev(NA, 1'b0, MDRO, RI, GA, 2'b00), "ld T7");

    tag = "ldi"; addr_calc(5'b00001);
    step(ev(NA, 1'b0, ZLO, RI, GA, 2'b00), "ldi T5");

    tag = "neg"; fetch({5'b10001, 27'h0});
    step(ev(5'b10001, 1'b0, RO, ZI, GB, 2'b00), "neg T3");
    step(ev(NA, 1'b0, ZLO, RI, GA, 2'b00), "neg T4");

    tag = "br"; fetch({5'b10011, 27'h0});
    step(ev(NA, 1'b0, RO, CONI, GA, 2'b00), "br T3");
    step(ev(NA, 1'b0, PCO, YI, 3'b000, 2'b00), "br T4");
    step(ev(5'b10011, 1'b0, CO, ZI, 3'b000, 2'b00), "br T5");
    step(ev(NA, 1'b0, ZLO, PCI, 3'b000, 2'b00), "br T6");

    tag = "jal"; fetch({5'b10101, 27'h0});
    step(ev(NA, 1'b0, PCO, R15I, 3'b000, 2'b00), "jal T3");
    step(ev(NA, 1'b0, RO, PCI, GA, 2'b00), "jal T4");

    tag = "jr";   one_step(5'b10100, RO, PCI);
    tag = "in";   one_step(5'b10110, INO, RI);
    tag = "out";  one_step(5'b10111, RO, OPI);
    tag = "mfhi"; one_step(5'b11000, HIO, RI);
    tag = "mflo"; one_step(5'b11001, LOO, RI);

    tag = "nop";   fetch({5'b11010, 27'h0});
    tag = "undef"; fetch({5'b11101, 27'h0});

    // stop high only mid-instruction must be ignored
    tag = "stop_pulse"; fetch(32'h19A20000);
    step(ev(NA, 1'b0, RO, YI, GB, 2'b00), "stop_pulse T3");
    step(ev(5'b00011, 1'b0, RO, ZI, GC, 2'b00), "stop_pulse T4");
    ctl.stop = 1'b1;
    step(ev(NA, 1'b0, ZLO, RI, GA, 2'b00), "stop_pulse T5");
    ctl.stop = 1'b0;

    tag = "stop_halt"; fetch(32'h19A20000);
    step(ev(NA, 1'b0, RO, YI, GB, 2'b00), "stop_halt T3");
    step(ev(5'b00011, 1'b0, RO, ZI, GC, 2'b00), "stop_halt T4");
    ctl.stop = 1'b1;
    step(ev(NA, 1'b0, ZLO, RI, GA, 2'b00), "stop_halt T5");
    step(Z, "stop_halt HALT");
    ctl.stop = 1'b0;
    for (int i = 0; i < 3; i++) step(Z, "stop_halt hold");
    tag = "stop_halt"; do_reset();

    tag = "abort"; addr_calc(5'b00000);
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb_exp.push_back(Z);
    sb_tag.push_back("abort at ld T5");
    step(Z, "abort rst");
    reset = 1'b1;
    tag = "restart"; fetch({5'b11010, 27'h0});

    tag = "halt"; fetch({5'b11011, 27'h0});
    for (int i = 0; i < 20; i++) step(Z, "halt hold");

    @(negedge clock);
    #1;
    if (sb_exp.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Mini SRC control unit that drives the ALU and the datapath. Sequences fetch (T0–T2) and per-instruction execute steps (T3–T7) from the opcode in `ir[31:27]`. Emits the 5-bit ALU `control` code plus `IncPC`, one-hot bus-source selects, register load strobes, register-field selects and memory strobes. Sits between the IR and the datapath (bus, register file, Y/Z, HI/LO, MAR/MDR, CON FF, ports).

## Interface
- No parameters.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ir`  in  32  instruction register; only `ir[31:27]` is used.
- `stop`  in  1  halt request, sampled at instruction boundaries.
- `alu_op`  out  5  ALU control code.
- `IncPC`  out  1  ALU PC-increment override.
- `bus_out`  out  10  one-hot bus source, MSB→LSB: PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Rout, BAout, Cout, InPortout.
- `reg_in`  out  12  load strobes, MSB→LSB: PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin, Rin, R15in.
- `gr_sel`  out  3  {Gra, Grb, Grc}.
- `mem`  out  2  {Read, Write}.
- `run`  out  1  high while sequencing.

## Operation
- States: RST, T0–T7, HALT. The state register is the only storage.
- All outputs are a Moore decode of (state, `ir[31:27]`).
- At most one `bus_out` bit is set. Unlisted signals are 0.
- `alu_op` = 5'b11010 except in a step that asserts Zin.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute (a→b→c means consecutive T3, T4, …):
  - add/sub/and/or/shr/shra/shl/ror/rol: Grb Rout Yin → Grc Rout Zin with `alu_op`=opcode → Zlowout Gra Rin.
  - addi/andi/ori: Grb Rout Yin → Cout Zin → Zlowout Gra Rin. `alu_op` is translated to 00011, 00101 and 00110 respectively (the ALU has no immediate codes).
  - mul/div: Gra Rout Yin → Grb Rout Zin (`alu_op`=01111 or 10000) → Zlowout LOin → Zhighout HIin.
  - neg/not: Grb Rout Zin (`alu_op`=opcode) → Zlowout Gra Rin.
  - ld: Grb BAout Yin → Cout Zin (00011) → Zlowout MARin → Read MDRin → MDRout Gra Rin.
  - ldi: Grb BAout Yin → Cout Zin (00011) → Zlowout Gra Rin.
  - st: same as ld through MARin → Gra Rout MDRin (Read=0) → Write.
  - branch: Gra Rout CONin → PCout Yin → Cout Zin (10011) → Zlowout PCin. The ALU selects taken or not-taken via its con_flag, so PCin is unconditional.
  - jr: Gra Rout PCin.
  - jal: PCout R15in → Gra Rout PCin.
  - in: InPortout Gra Rin. out: Gra Rout OutPortin. mfhi: HIout Gra Rin. mflo: LOout Gra Rin.
  - nop and undefined codes (11100–11111): no execute steps.
  - halt (11011): T2 → HALT.
- After the last step of an instruction: go to HALT if `stop`=1, else T0.
- HALT: all outputs 0, `run`=0. Held until reset.

## Timing
- `reset`=0 asynchronously forces RST. In RST all outputs are 0 and `run`=0.
- First rising edge after `reset` goes high: RST → T0, `run`=1.
- Reset mid-instruction aborts immediately. No strobe remains asserted after the reset assertion.
- One step per clock. Strobes are valid for the whole cycle; loads occur on the closing edge.
- Cycles per instruction, fetch included:
  - ALU reg/imm, ldi: 6.
  - neg/not, jal: 5.
  - mul/div, branch: 7.
  - ld/st: 8.
  - jr/in/out/mfhi/mflo: 4.
  - nop: 3.
- Memory is fixed-latency: data must be valid in the cycle Read is asserted with MDRin.
- `stop` is sampled only on the final edge of an instruction. A `stop` pulse that is high at no instruction boundary is ignored.
- halt and `stop`=1 both reach HALT on the same edge; the result is identical.

## Test plan
- Reset: `reset`=0 → all outputs 0, `run`=0. Release → T0 shows `bus_out`=10'b1000000000, `reg_in`=12'b010001000000, `IncPC`=1.
- add (`ir`=32'h19A20000): T4 `alu_op`=00011, `gr_sel`=001, Zin=1. T5 Zlowout Rin Gra. T6 is T0; 6 cycles total.
- andi (`ir[31:27]`=01101): T4 `alu_op`=00101 with Cout. Also check addi → 00011 and ori → 00110.
- mul (01111): T4 `alu_op`=01111. T5 LOin with Zlowout. T6 HIin with Zhighout. Next fetch at cycle 8.
- st (00010): T6 `mem`=00 with MDRin and Rout. T7 `mem`=01. ld (00000): T6 `mem`=10 with MDRin.
- halt (11011) → HALT after T2, `run`=0, held 20 cycles. Separately: `stop`=1 during T4 of add → HALT after T5. `reset`=0 during ld T5 → outputs 0 immediately, restart at T0.
